// File: rtl/mul_add_seq.sv
// Time-multiplexed polyphase decimation FIR: one multiplier, N-deep sample history, one output per D inputs.
// Define MUL_ADD_SEQ_SYM_EN for symmetric (linear-phase) folding with ceil(N/2) stored coefficients.
module mul_add_seq #(
  parameter int gp_idata_width       = 8,
  parameter int gp_coeff_width       = 8,
  parameter int gp_coeff_length      = 17,
  parameter int gp_decimation_factor = 4,
  parameter int gp_odata_width       = gp_idata_width + gp_coeff_width + $clog2(gp_coeff_length)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic [gp_idata_width-1:0]           i_data,
  input  logic                                i_coeff_wr,
  input  logic [$clog2(gp_coeff_length)-1:0]  i_coeff_addr,
  input  logic [gp_coeff_width-1:0]           i_coeff_data,
  output logic                                o_valid,
  output logic [gp_odata_width-1:0]           o_data,
  output logic                                o_busy
);

  localparam int AW  = $clog2(gp_coeff_length);
`ifdef MUL_ADD_SEQ_SYM_EN
  localparam int CN  = (gp_coeff_length + 1) / 2;
  localparam int PAW = gp_idata_width + 1;
`else
  localparam int CN  = gp_coeff_length;
  localparam int PAW = gp_idata_width;
`endif
  localparam int CAW = (CN > 1) ? $clog2(CN) : 1;
  localparam int PRW = PAW + gp_coeff_width;
  localparam int PW  = (gp_decimation_factor > 1) ? $clog2(gp_decimation_factor) : 1;

  localparam logic [AW:0]    CN_L      = (AW+1)'(CN);
  localparam logic [AW-1:0]  LAST_IDX  = AW'(gp_coeff_length - 1);
  localparam logic [CAW-1:0] STEP_LAST = CAW'(CN - 1);
  localparam logic [PW-1:0]  PH_LAST   = PW'(gp_decimation_factor - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                            state;
  logic signed [gp_idata_width-1:0]  buf_q   [gp_coeff_length];
  logic signed [gp_coeff_width-1:0]  coeff_q [CN];
  logic [AW-1:0]                     wptr;
  logic [AW-1:0]                     rd_lo;
  logic [CAW-1:0]                    step;
  logic [PW-1:0]                     phase;
  logic signed [gp_odata_width-1:0]  acc;
  logic signed [PAW-1:0]             pre;
  logic signed [PRW-1:0]             prod;
  logic signed [gp_odata_width-1:0]  prod_ext;
`ifdef MUL_ADD_SEQ_SYM_EN
  localparam logic [CAW-1:0] STEP_MID = CAW'(gp_coeff_length / 2);
  logic [AW-1:0]                     rd_hi;
`endif

  function automatic logic [AW-1:0] idx_inc(input logic [AW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [AW-1:0] idx_dec(input logic [AW-1:0] i);
    return (i == '0) ? LAST_IDX : i - 1'b1;
  endfunction

  // Single shared multiplier; rd_lo walks backwards from the newest sample.
  always_comb begin
    pre = '0;
`ifdef MUL_ADD_SEQ_SYM_EN
    if ((gp_coeff_length % 2 == 1) && (step == STEP_MID))
      pre = {buf_q[rd_lo][gp_idata_width-1], buf_q[rd_lo]};
    else
      pre = {buf_q[rd_lo][gp_idata_width-1], buf_q[rd_lo]}
          + {buf_q[rd_hi][gp_idata_width-1], buf_q[rd_hi]};
`else
    pre = buf_q[rd_lo];
`endif
    prod     = coeff_q[step] * pre;
    prod_ext = {{(gp_odata_width-PRW){prod[PRW-1]}}, prod};
  end

  // Handshake: a sample moves on any clock edge where i_valid && o_ready;
  // o_ready is high only in IDLE, and the source holds i_data while it is low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      wptr    <= '0;
      rd_lo   <= '0;
      step    <= '0;
      phase   <= '0;
      acc     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
      o_busy  <= 1'b0;
`ifdef MUL_ADD_SEQ_SYM_EN
      rd_hi   <= '0;
`endif
      for (int i = 0; i < gp_coeff_length; i++) buf_q[i] <= '0;
      for (int i = 0; i < CN; i++) coeff_q[i] <= '0;
    end else begin
      o_valid <= 1'b0;
      if (i_coeff_wr && (state != S_MAC) && ({1'b0, i_coeff_addr} < CN_L))
        coeff_q[i_coeff_addr[CAW-1:0]] <= i_coeff_data;
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            buf_q[wptr] <= i_data;
            wptr        <= idx_inc(wptr);
            if (phase == PH_LAST) begin
              phase   <= '0;
              state   <= S_MAC;
              o_ready <= 1'b0;
              o_busy  <= 1'b1;
              acc     <= '0;
              step    <= '0;
              rd_lo   <= wptr;
`ifdef MUL_ADD_SEQ_SYM_EN
              rd_hi   <= idx_inc(wptr);
`endif
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        S_MAC: begin
          acc   <= acc + prod_ext;
          step  <= step + 1'b1;
          rd_lo <= idx_dec(rd_lo);
`ifdef MUL_ADD_SEQ_SYM_EN
          rd_hi <= idx_inc(rd_hi);
`endif
          if (step == STEP_LAST) begin
            state  <= S_OUT;
            o_busy <= 1'b0;
          end
        end
        S_OUT: begin
          o_data  <= acc;
          o_valid <= 1'b1;
          o_ready <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_add_seq.sv
// Directed bench for mul_add_seq: a small N=4/D=2 instance and a default-parameter instance.
module tb_mul_add_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MUL_ADD_SEQ_SYM_EN
  localparam int LAT_S = 3;
  localparam int LAT_D = 10;
  localparam logic [17:0] EXP_S2   = 18'd15;
  localparam logic [17:0] EXP_S_WR = 18'd63;
  localparam logic [4:0]  BAD_ADDR = 5'd9;
`else
  localparam int LAT_S = 5;
  localparam int LAT_D = 18;
  localparam logic [17:0] EXP_S2   = 18'd20;
  localparam logic [17:0] EXP_S_WR = 18'd64;
  localparam logic [4:0]  BAD_ADDR = 5'd17;
`endif

  // small instance: N=4, D=2
  logic        s_valid = 0, s_ready, s_cwr = 0, s_ovalid, s_busy;
  logic [7:0]  s_data = 0, s_cdata = 0;
  logic [1:0]  s_caddr = 0;
  logic [17:0] s_odata;

  // default instance: N=17, D=4
  logic        d_valid = 0, d_ready, d_cwr = 0, d_ovalid, d_busy;
  logic [7:0]  d_data = 0, d_cdata = 0;
  logic [4:0]  d_caddr = 0;
  logic [20:0] d_odata;

  mul_add_seq #(.gp_coeff_length(4), .gp_decimation_factor(2)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_valid(s_valid), .o_ready(s_ready), .i_data(s_data),
    .i_coeff_wr(s_cwr), .i_coeff_addr(s_caddr), .i_coeff_data(s_cdata),
    .o_valid(s_ovalid), .o_data(s_odata), .o_busy(s_busy));

  mul_add_seq dut_d (
    .i_clk(clk), .i_rst(rst), .i_valid(d_valid), .o_ready(d_ready), .i_data(d_data),
    .i_coeff_wr(d_cwr), .i_coeff_addr(d_caddr), .i_coeff_data(d_cdata),
    .o_valid(d_ovalid), .o_data(d_odata), .o_busy(d_busy));

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wr_s(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk); s_cwr = 1'b1; s_caddr = a; s_cdata = v;
    @(posedge clk); #1; s_cwr = 1'b0;
  endtask

  task automatic prog_s();
    wr_s(2'd0, 8'd1); wr_s(2'd1, 8'd2); wr_s(2'd2, 8'd3); wr_s(2'd3, 8'd4);
  endtask

  task automatic wr_d(input logic [4:0] a, input logic [7:0] v);
    @(negedge clk); d_cwr = 1'b1; d_caddr = a; d_cdata = v;
    @(posedge clk); #1; d_cwr = 1'b0;
  endtask

  task automatic send_s(input logic [7:0] v, output bit ok);
    ok = 1'b0;
    @(negedge clk); s_valid = 1'b1; s_data = v;
    for (int g = 0; g < 100; g++) begin
      if (s_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1; s_valid = 1'b0;
  endtask

  task automatic send_d(input logic [7:0] v, output bit ok);
    ok = 1'b0;
    @(negedge clk); d_valid = 1'b1; d_data = v;
    for (int g = 0; g < 100; g++) begin
      if (d_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1; d_valid = 1'b0;
  endtask

  // Called just after the accepting edge; lat counts edges until o_valid is seen.
  task automatic wait_s(input bit wr_mid, output int lat, output int stall,
                        output logic [17:0] val, output bit extra, output bit busy_wr);
    lat = 0; stall = 0; val = '0; extra = 1'b0; busy_wr = 1'b0;
    if (!s_ready) stall++;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (s_ovalid) begin lat = c; val = s_odata; break; end
      if (!s_ready) stall++;
      if (wr_mid && c == 1) begin
        busy_wr = s_busy; s_cwr = 1'b1; s_caddr = 2'd0; s_cdata = 8'd5;
      end
      if (wr_mid && c == 2) s_cwr = 1'b0;
    end
    s_cwr = 1'b0;
    if (lat != 0) begin @(posedge clk); #1; extra = s_ovalid; end
  endtask

  task automatic wait_d(output int lat, output logic [20:0] val, output bit extra);
    lat = 0; val = '0; extra = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (d_ovalid) begin lat = c; val = d_odata; break; end
    end
    if (lat != 0) begin @(posedge clk); #1; extra = d_ovalid; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = i[0]; d_valid = ~i[0]; s_cwr = i[1]; d_cwr = i[0];
      s_data = 8'($urandom_range(0, 255)); d_data = 8'($urandom_range(0, 255));
      s_cdata = 8'd7; d_cdata = 8'd7;
      @(negedge clk);
      n_tests++;
      if ({s_ovalid, s_odata, s_ready, s_busy} !== {1'b0, 18'd0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_small: got v=%b d=%0d r=%b b=%b expected v=0 d=0 r=1 b=0",
                 s_ovalid, s_odata, s_ready, s_busy);
      end
      n_tests++;
      if ({d_ovalid, d_odata, d_ready, d_busy} !== {1'b0, 21'd0, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_default: got v=%b d=%0d r=%b b=%b expected v=0 d=0 r=1 b=0",
                 d_ovalid, d_odata, d_ready, d_busy);
      end
    end
    s_valid = 0; d_valid = 0; s_cwr = 0; d_cwr = 0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if ({s_ovalid, s_ready, s_busy, d_ovalid, d_ready, d_busy} !== 6'b010_010) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b expected 010010",
               {s_ovalid, s_ready, s_busy, d_ovalid, d_ready, d_busy});
    end
  endtask

  task automatic test_stream();
    bit ok1, ok2, extra, bw;
    int lat, stall;
    logic [17:0] val;
    do_reset();
    prog_s();
    send_s(8'd1, ok1); send_s(8'd2, ok2);
    wait_s(1'b0, lat, stall, val, extra, bw);
    n_tests++;
    if (!(ok1 && ok2) || lat !== LAT_S) begin
      n_fail++; $display("FAIL stream_lat1: got %0d expected %0d", lat, LAT_S);
    end
    n_tests++;
    if (stall !== LAT_S) begin
      n_fail++; $display("FAIL stream_stall1: got %0d expected %0d", stall, LAT_S);
    end
    n_tests++;
    if (val !== 18'd4 || extra !== 1'b0) begin
      n_fail++; $display("FAIL stream_out1: got %0d extra=%b expected 4 extra=0", val, extra);
    end
    send_s(8'd3, ok1); send_s(8'd4, ok2);
    wait_s(1'b0, lat, stall, val, extra, bw);
    n_tests++;
    if (!(ok1 && ok2) || lat !== LAT_S) begin
      n_fail++; $display("FAIL stream_lat2: got %0d expected %0d", lat, LAT_S);
    end
    n_tests++;
    if (val !== EXP_S2 || extra !== 1'b0) begin
      n_fail++; $display("FAIL stream_out2: got %0d extra=%b expected %0d extra=0", val, extra, EXP_S2);
    end
  endtask

  task automatic test_coeff_busy();
    bit ok1, ok2, extra, bw;
    int lat, stall;
    logic [17:0] val;
    do_reset();
    prog_s();
    send_s(8'd1, ok1); send_s(8'd2, ok2);
    wait_s(1'b1, lat, stall, val, extra, bw);
    n_tests++;
    if (bw !== 1'b1 || val !== 18'd4) begin
      n_fail++; $display("FAIL busy_wr_out1: got busy=%b out=%0d expected busy=1 out=4", bw, val);
    end
    send_s(8'd3, ok1); send_s(8'd4, ok2);
    wait_s(1'b0, lat, stall, val, extra, bw);
    n_tests++;
    if (val !== EXP_S2) begin
      n_fail++; $display("FAIL busy_wr_ignored: got %0d expected %0d", val, EXP_S2);
    end
    wr_s(2'd0, 8'd5);
    send_s(8'd5, ok1); send_s(8'd6, ok2);
    wait_s(1'b0, lat, stall, val, extra, bw);
    n_tests++;
    if (val !== EXP_S_WR) begin
      n_fail++; $display("FAIL idle_wr_applied: got %0d expected %0d", val, EXP_S_WR);
    end
  endtask

  task automatic test_reset_mid_mac();
    bit ok1, ok2, extra, bw;
    int lat, stall, seen;
    logic [17:0] val;
    do_reset();
    prog_s();
    send_s(8'd1, ok1); send_s(8'd2, ok2);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    n_tests++;
    if ({s_ready, s_busy} !== 2'b10) begin
      n_fail++; $display("FAIL mid_reset_state: got r/b=%b expected 10", {s_ready, s_busy});
    end
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (s_ovalid) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL mid_reset_no_valid: got %0d pulses expected 0", seen);
    end
    prog_s();
    send_s(8'd7, ok1); send_s(8'd9, ok2);
    wait_s(1'b0, lat, stall, val, extra, bw);
    n_tests++;
    if (val !== 18'd23 || lat !== LAT_S) begin
      n_fail++; $display("FAIL mid_reset_fresh: got %0d lat=%0d expected 23 lat=%0d", val, lat, LAT_S);
    end
  endtask

  task automatic test_default();
    bit ok, all_ok, extra;
    int lat;
    logic [20:0] val;
    do_reset();
    wr_d(5'd3, 8'h80);
    wr_d(BAD_ADDR, 8'h7f);
    all_ok = 1'b1;
    send_d(8'h80, ok); all_ok &= ok;
    send_d(8'h00, ok); all_ok &= ok;
    send_d(8'h00, ok); all_ok &= ok;
    @(negedge clk);
    n_tests++;
    if ({d_ready, d_busy, d_ovalid} !== 3'b100) begin
      n_fail++; $display("FAIL default_no_early_mac: got r/b/v=%b expected 100", {d_ready, d_busy, d_ovalid});
    end
    send_d(8'h00, ok); all_ok &= ok;
    wait_d(lat, val, extra);
    n_tests++;
    if (!all_ok || lat !== LAT_D) begin
      n_fail++; $display("FAIL default_lat: got %0d expected %0d", lat, LAT_D);
    end
    n_tests++;
    if (val !== 21'd16384 || extra !== 1'b0) begin
      n_fail++; $display("FAIL default_out: got %0d extra=%b expected 16384 extra=0", val, extra);
    end
    n_tests++;
    if (d_odata !== 21'd16384) begin
      n_fail++; $display("FAIL default_hold: got %0d expected 16384", d_odata);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_coeff_busy();
    test_reset_mid_mac();
    test_default();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
